adder_sum_accumulator: RTL and testbench

Sequential stage directly downstream of `ripple_carry_adder`. It consumes the adder's `{cout, sum}` result through a valid/ready handshake and accumulates a programmed number of results into a wide running total. It reports completion with a one-cycle `done` pulse, and flags wrap-around of the total with a sticky overflow bit.

---
 rtl/adder_pkg.sv | 16 +
 rtl/ripple_carry_adder.sv | 31 +++
 rtl/adder_sum_accumulator.sv | 89 ++++++++
 tb/tb_adder_sum_accumulator.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// adder_pkg : shared adder-path width default and FSM state encoding. Rev 1.0
// ---------------------------------------------------------------------------
package adder_pkg;

    localparam int ADDER_PROC_SIZE = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage : adder_pkg
`default_nettype wire

// File: rtl/ripple_carry_adder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// ripple_carry_adder : PROC_SIZE-bit ripple-carry adder with carry in/out. Rev 1.0
// ---------------------------------------------------------------------------
module ripple_carry_adder
    import adder_pkg::*;
#(
    parameter int PROC_SIZE = ADDER_PROC_SIZE
) (
    input  logic [PROC_SIZE-1:0] a_i,
    input  logic [PROC_SIZE-1:0] b_i,
    input  logic                 cin_i,
    output logic [PROC_SIZE-1:0] sum_o,
    output logic                 cout_o
);

    logic [PROC_SIZE:0] carry;

    assign carry[0] = cin_i;

    generate
        for (genvar i = 0; i < PROC_SIZE; i++) begin : g_bit
            assign sum_o[i]   = a_i[i] ^ b_i[i] ^ carry[i];
            assign carry[i+1] = (a_i[i] & b_i[i]) | (carry[i] & (a_i[i] ^ b_i[i]));
        end
    endgenerate

    assign cout_o = carry[PROC_SIZE];

endmodule : ripple_carry_adder
`default_nettype wire

// File: rtl/adder_sum_accumulator.sv
`default_nettype none
// ---------------------------------------------------------------------------
// adder_sum_accumulator : accumulates a programmed number of {cout,sum}
// results into a wide total with sticky wrap flag and done pulse. Rev 1.0
// ---------------------------------------------------------------------------
module adder_sum_accumulator
    import adder_pkg::*;
#(
    parameter int PROC_SIZE   = ADDER_PROC_SIZE,
    parameter int ACC_WIDTH   = 32,
    parameter int COUNT_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start_i,
    input  logic [COUNT_WIDTH-1:0] num_samples_i,
    input  logic [PROC_SIZE-1:0]   sum_i,
    input  logic                   cout_i,
    input  logic                   in_valid_i,
    output logic                   in_ready_o,
    output logic [ACC_WIDTH-1:0]   acc_out_o,
    output logic                   acc_overflow_o,
    output logic [COUNT_WIDTH-1:0] sample_cnt_o,
    output logic                   busy_o,
    output logic                   done_o
);

    state_t                 state_q;
    logic [ACC_WIDTH-1:0]   acc_q;
    logic                   ovf_q;
    logic [COUNT_WIDTH-1:0] cnt_q;
    logic [COUNT_WIDTH-1:0] target_q;

    logic [ACC_WIDTH:0]     acc_d;
    logic [COUNT_WIDTH-1:0] cnt_d;

    // MSB of the widened sum is the wrap carry of the ACC_WIDTH-bit total
    assign acc_d = {1'b0, acc_q} + {{(ACC_WIDTH-PROC_SIZE){1'b0}}, cout_i, sum_i};
    assign cnt_d = cnt_q + {{(COUNT_WIDTH-1){1'b0}}, 1'b1};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            acc_q    <= '0;
            ovf_q    <= 1'b0;
            cnt_q    <= '0;
            target_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        target_q <= num_samples_i;
                        acc_q    <= '0;
                        ovf_q    <= 1'b0;
                        cnt_q    <= '0;
                        state_q  <= (num_samples_i != '0) ? ST_ACCUM : ST_DONE;
                    end
                end
                ST_ACCUM: begin
                    if (in_valid_i) begin
                        acc_q <= acc_d[ACC_WIDTH-1:0];
                        cnt_q <= cnt_d;
                        if (acc_d[ACC_WIDTH]) begin
                            ovf_q <= 1'b1;
                        end
                        if (cnt_d == target_q) begin
                            state_q <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready_o     = (state_q == ST_ACCUM);
    assign busy_o         = (state_q == ST_ACCUM) || (state_q == ST_DONE);
    assign done_o         = (state_q == ST_DONE);
    assign acc_out_o      = acc_q;
    assign acc_overflow_o = ovf_q;
    assign sample_cnt_o   = cnt_q;

endmodule : adder_sum_accumulator
`default_nettype wire

// File: tb/tb_adder_sum_accumulator.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_adder_sum_accumulator : ripple_carry_adder feeding two accumulators
// (32-bit and 17-bit totals), checked against an arithmetic model. Rev 1.0
// ---------------------------------------------------------------------------
module tb_adder_sum_accumulator;

    logic        clk;
    logic        rst;
    logic        start;
    logic [7:0]  num;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        in_valid;

    logic [15:0] add_sum;
    logic        add_cout;

    logic        rdy32, ovf32, busy32, done32;
    logic [31:0] acc32;
    logic [7:0]  cnt32;
    logic        rdy17, ovf17, busy17, done17;
    logic [16:0] acc17;
    logic [7:0]  cnt17;

    int n_cmp  = 0;
    int n_fail = 0;

    ripple_carry_adder #(16) u_adder (
        .a_i    (a),
        .b_i    (b),
        .cin_i  (cin),
        .sum_o  (add_sum),
        .cout_o (add_cout)
    );

    adder_sum_accumulator #(.PROC_SIZE(16), .ACC_WIDTH(32), .COUNT_WIDTH(8)) u_acc32 (
        .clk            (clk),
        .rst            (rst),
        .start_i        (start),
        .num_samples_i  (num),
        .sum_i          (add_sum),
        .cout_i         (add_cout),
        .in_valid_i     (in_valid),
        .in_ready_o     (rdy32),
        .acc_out_o      (acc32),
        .acc_overflow_o (ovf32),
        .sample_cnt_o   (cnt32),
        .busy_o         (busy32),
        .done_o         (done32)
    );

    adder_sum_accumulator #(.PROC_SIZE(16), .ACC_WIDTH(17), .COUNT_WIDTH(8)) u_acc17 (
        .clk            (clk),
        .rst            (rst),
        .start_i        (start),
        .num_samples_i  (num),
        .sum_i          (add_sum),
        .cout_i         (add_cout),
        .in_valid_i     (in_valid),
        .in_ready_o     (rdy17),
        .acc_out_o      (acc17),
        .acc_overflow_o (ovf17),
        .sample_cnt_o   (cnt17),
        .busy_o         (busy17),
        .done_o         (done17)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          n;
        logic [15:0] av[3];
        logic [15:0] bv[3];
        int          gap;
        logic [31:0] exp32;
        logic [16:0] exp17;
        logic        expovf17;
    } vec_t;

    vec_t vt[4];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Expected totals come straight from the exact integer sum of accepted results
    task automatic check_state(input string tag, input longint tot, input int cnt,
                               input bit dn, input bit rdy, input bit bsy);
        longint m17;
        m17 = tot % 131072;
        chk({tag, " acc32"},  acc32, tot[31:0]);
        chk({tag, " ovf32"},  ovf32, tot >= 64'h1_0000_0000);
        chk({tag, " cnt32"},  cnt32, cnt);
        chk({tag, " done32"}, done32, dn);
        chk({tag, " rdy32"},  rdy32, rdy);
        chk({tag, " busy32"}, busy32, bsy);
        chk({tag, " acc17"},  acc17, m17);
        chk({tag, " ovf17"},  ovf17, tot >= 131072);
        chk({tag, " cnt17"},  cnt17, cnt);
        chk({tag, " done17"}, done17, dn);
        chk({tag, " rdy17"},  rdy17, rdy);
        chk({tag, " busy17"}, busy17, bsy);
    endtask

    task automatic do_run(input int n, input logic [15:0] aq[$], input logic [15:0] bq[$],
                          input logic cq[$], input int gap, input bit ign);
        longint tot;
        tot      = 0;
        in_valid = 1'b0;
        start    = 1'b1;
        num      = n[7:0];
        tick();
        start = 1'b0;
        num   = 8'($urandom);
        if (n == 0) begin
            check_state("zero run", 0, 0, 1, 0, 1);
            tick();
            check_state("zero idle", 0, 0, 0, 0, 0);
            return;
        end
        check_state("run start", 0, 0, 0, 1, 1);
        for (int k = 0; k < n; k++) begin
            if (k > 0) begin
                for (int g = 0; g < gap; g++) begin
                    a   = 16'($urandom);
                    b   = 16'($urandom);
                    cin = 1'($urandom);
                    tick();
                    check_state("gap", tot, k, 0, 1, 1);
                end
            end
            a        = aq[k];
            b        = bq[k];
            cin      = cq[k];
            in_valid = 1'b1;
            if (ign && k == 1) begin
                start = 1'b1;
                num   = 8'd1;
            end
            tick();
            in_valid = 1'b0;
            start    = 1'b0;
            tot += longint'(aq[k]) + longint'(bq[k]) + longint'(cq[k]);
            if (k == n - 1) check_state("done cycle", tot, n, 1, 0, 1);
            else            check_state("accum", tot, k + 1, 0, 1, 1);
        end
        if (ign) begin
            start = 1'b1;
            num   = 8'd3;
        end
        a = 16'($urandom);
        b = 16'($urandom);
        tick();
        start = 1'b0;
        check_state("idle hold", tot, n, 0, 0, 0);
    endtask

    initial begin
        logic [15:0] aq[$];
        logic [15:0] bq[$];
        logic        cq[$];

        vt[0] = '{n: 3, av: '{16'h0001, 16'h0010, 16'hFFFF}, bv: '{16'h0002, 16'h0003, 16'h001F},
                  gap: 0, exp32: 32'h0001_0034, exp17: 17'h10034, expovf17: 1'b0};
        vt[1] = '{n: 2, av: '{16'hFFFF, 16'hFFFF, 16'h0}, bv: '{16'h0000, 16'hFFFF, 16'h0},
                  gap: 2, exp32: 32'h0002_FFFD, exp17: 17'h0FFFD, expovf17: 1'b1};
        vt[2] = '{n: 2, av: '{16'hFFFF, 16'hFFFF, 16'h0}, bv: '{16'hFFFF, 16'hFFFF, 16'h0},
                  gap: 0, exp32: 32'h0003_FFFC, exp17: 17'h1FFFC, expovf17: 1'b1};
        vt[3] = '{n: 1, av: '{16'h1234, 16'h0, 16'h0}, bv: '{16'h4321, 16'h0, 16'h0},
                  gap: 0, exp32: 32'h0000_5555, exp17: 17'h05555, expovf17: 1'b0};

        rst      = 1'b1;
        start    = 1'b1;
        num      = 8'd4;
        a        = 16'h1234;
        b        = 16'h0001;
        cin      = 1'b0;
        in_valid = 1'b1;
        tick();
        tick();
        check_state("reset", 0, 0, 0, 0, 0);
        rst   = 1'b0;
        start = 1'b0;
        tick();
        tick();
        check_state("idle valid", 0, 0, 0, 0, 0);
        in_valid = 1'b0;

        for (int v = 0; v < 4; v++) begin
            aq.delete(); bq.delete(); cq.delete();
            for (int k = 0; k < vt[v].n; k++) begin
                aq.push_back(vt[v].av[k]);
                bq.push_back(vt[v].bv[k]);
                cq.push_back(1'b0);
            end
            do_run(vt[v].n, aq, bq, cq, vt[v].gap, v == 0);
            chk($sformatf("vec%0d acc32", v), acc32, vt[v].exp32);
            chk($sformatf("vec%0d acc17", v), acc17, vt[v].exp17);
            chk($sformatf("vec%0d ovf17", v), ovf17, vt[v].expovf17);
            chk($sformatf("vec%0d cnt", v),   cnt32, vt[v].n);
        end

        do_run(0, aq, bq, cq, 0, 1'b0);

        // Reset after 2 of 5 samples, then a fresh run
        in_valid = 1'b0;
        start    = 1'b1;
        num      = 8'd5;
        tick();
        start    = 1'b0;
        a        = 16'h8000;
        b        = 16'h8000;
        in_valid = 1'b1;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst      = 1'b0;
        in_valid = 1'b0;
        check_state("rst mid-run", 0, 0, 0, 0, 0);
        tick();
        check_state("after rst", 0, 0, 0, 0, 0);

        for (int r = 0; r < 20; r++) begin
            int n;
            n = $urandom_range(1, 12);
            aq.delete(); bq.delete(); cq.delete();
            for (int k = 0; k < n; k++) begin
                aq.push_back(16'($urandom));
                bq.push_back(16'($urandom));
                cq.push_back(1'($urandom));
            end
            do_run(n, aq, bq, cq, $urandom_range(0, 2), 1'($urandom));
        end

        aq.delete(); bq.delete(); cq.delete();
        for (int k = 0; k < 255; k++) begin
            aq.push_back(16'hFFFF);
            bq.push_back(16'hFFFF);
            cq.push_back(1'b1);
        end
        do_run(255, aq, bq, cq, 0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule : tb_adder_sum_accumulator
`default_nettype wire
